// File: rtl/io_timer.sv
// io_timer: two-channel down-counting timer/counter on the Minisys I/O bus.
// Each channel counts from a programmed INIT value using either the CPU clock
// or synchronized rising edges on cnt_in[n]. Terminal count sets a sticky
// DONE flag (read-to-clear) and emits a registered one-cycle pulse.
module io_timer #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ioread,
    input  logic             iowrite,
    input  logic             timerctrl,
    input  logic [2:0]       address,
    input  logic [WIDTH-1:0] write_data,
    input  logic [1:0]       cnt_in,
    output logic [WIDTH-1:0] read_data,
    output logic [1:0]       pulse_out
);

    logic             wr;
    logic             rd;
    logic [1:0]       sel;
    logic             unused_addr0;

    logic [1:0][WIDTH-1:0] status_v;
    logic [1:0][WIDTH-1:0] count_v;

    assign wr  = timerctrl & iowrite;
    assign rd  = timerctrl & ioread;
    assign sel = address[2:1];
    // Byte lane bit carries no register information.
    assign unused_addr0 = address[0];

    for (genvar ch = 0; ch < 2; ch++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync;
        logic                   prev;
        logic                   src;
        logic                   rpt;
        logic                   run;
        logic                   done;
        logic                   pulse;
        logic [WIDTH-1:0]       init;
        logic [WIDTH-1:0]       count;

        logic mode_wr;
        logic init_wr;
        logic stat_rd;
        logic rise;
        logic tick;
        logic term;

        assign mode_wr = wr && (sel == 2'(ch));
        assign init_wr = wr && (sel == 2'(ch + 2));
        assign stat_rd = rd && (sel == 2'(ch));
        assign rise    = sync[SYNC_STAGES-1] & ~prev;
        // A register write to this channel swallows any tick in the same cycle.
        assign tick    = run & (src ? rise : 1'b1) & ~mode_wr & ~init_wr;
        assign term    = tick && (count == WIDTH'(1));

        // Synchronizer and edge history run regardless of RUN, so edges seen
        // while stopped are simply dropped rather than counted later.
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                sync <= '0;
                prev <= 1'b0;
            end else begin
                sync <= {sync[SYNC_STAGES-2:0], cnt_in[ch]};
                prev <= sync[SYNC_STAGES-1];
            end
        end

        // Channel registers: writes first, then counting, then DONE priority
        // (INIT write clears, terminal sets, STATUS read clears).
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                src   <= 1'b0;
                rpt   <= 1'b0;
                run   <= 1'b0;
                done  <= 1'b0;
                pulse <= 1'b0;
                init  <= '0;
                count <= '0;
            end else begin
                pulse <= term;
                if (mode_wr) begin
                    src <= write_data[0];
                    rpt <= write_data[1];
                    run <= 1'b0;
                end
                if (init_wr) begin
                    init  <= write_data;
                    count <= write_data;
                    run   <= |write_data;
                end
                if (tick) begin
                    if (term) begin
                        count <= rpt ? init : '0;
                        run   <= rpt;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                if (init_wr)
                    done <= 1'b0;
                else if (term)
                    done <= 1'b1;
                else if (stat_rd)
                    done <= 1'b0;
            end
        end

        assign status_v[ch]  = {run, {(WIDTH-2){1'b0}}, done};
        assign count_v[ch]   = count;
        assign pulse_out[ch] = pulse;
    end

    // Shared read mux; idle bus reads as zero.
    always_comb begin
        read_data = '0;
        if (rd) begin
            case (sel)
                2'd0:    read_data = status_v[0];
                2'd1:    read_data = status_v[1];
                2'd2:    read_data = count_v[0];
                default: read_data = count_v[1];
            endcase
        end
    end

endmodule

// File: doc/io_timer.md
# io_timer

Memory-mapped two-channel 16-bit timer/counter peripheral on the Minisys I/O bus. It sits beside the LED and switch peripherals and answers CPU `ioread`/`iowrite` cycles decoded by `memorio` via a chip-select. Each channel counts down from a programmed initial value, using either the CPU clock or rising edges on an external input. On terminal count it raises a status flag and a one-cycle output pulse.

## Interface
Parameters:
- WIDTH, 16, counter/register width (bus data width to the block)
- SYNC_STAGES, 2, synchronizer flops on external count inputs (>=2)

Ports:
- clock  in  1  CPU clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- ioread  in  1  CPU I/O read strobe
- iowrite  in  1  CPU I/O write strobe
- timerctrl  in  1  chip select from memorio (address in 0xFFFFFC20–0xFFFFFC27)
- address  in  3  byte offset within block; address[2:1] selects register, address[0] ignored
- write_data  in  16  CPU write data
- cnt_in  in  2  external count sources, ch0 = bit0, ch1 = bit1; asynchronous
- read_data  out  16  register read data
- pulse_out  out  2  terminal-count pulses, ch0 = bit0

## Operation
- Register map by address[2:1]:
  - 0: write = MODE0, read = STATUS0
  - 1: write = MODE1, read = STATUS1
  - 2: write = INIT0, read = COUNT0
  - 3: write = INIT1, read = COUNT1
- MODE bit0 SRC selects the count source: 0 = clock, 1 = external edge. MODE bit1 RPT: 1 = auto-reload. Other bits are ignored and not stored.
- STATUS layout: bit15 RUN, bit0 DONE, all others 0.
- Write occurs when timerctrl & iowrite are both high.
- Write MODEn: stores SRC/RPT, clears RUN, leaves COUNT and DONE unchanged. This stops the channel.
- Write INITn with value v:
  - stores INIT = v and sets COUNT = v
  - RUN = 1 if v != 0, otherwise RUN = 0
  - DONE is cleared
- Tick: for clock source, every cycle while RUN. For external source, each synchronized rising edge of cnt_in[n] while RUN.
- On a tick with COUNT > 1: COUNT <= COUNT − 1.
- On a tick with COUNT == 1 (terminal), DONE <= 1 and pulse_out[n] <= 1 for one cycle. Then:
  - RPT = 1: COUNT <= INIT, RUN stays 1
  - RPT = 0: COUNT <= 0, RUN <= 0
- Read occurs when timerctrl & ioread are both high. read_data is combinational from the selected register. With no read selected, read_data = 0.
- Reading STATUSn clears DONE at the end of that cycle (read-to-clear).
- Simultaneous events:
  - terminal tick and STATUS read in the same cycle: DONE ends at 1 (set wins), and the read returns the pre-edge value
  - write INITn or MODEn in the same cycle as a tick: the write wins and the tick is discarded
  - iowrite and ioread both high: the write is performed; read_data still reflects pre-edge state
- The edge detector and synchronizer run continuously, independent of RUN. An edge arriving while stopped is not counted later.

## Timing
- Reset values: read_data 0, pulse_out 0. Also MODE, INIT, COUNT, RUN and DONE all 0; synchronizer and edge history flops 0.
- Reset is asserted asynchronously and released synchronously by the upstream reset logic. Reset mid-count aborts immediately and pulse_out drops in the same instant.
- Register writes take effect on the clock edge ending the write cycle.
- Clock source: the first decrement occurs on the edge after the INIT write edge. For INIT = v, the terminal tick happens v cycles after the write edge, and pulse_out is high during cycle v+1.
- External source: a cnt_in rise is counted SYNC_STAGES+1 edges after it is sampled, i.e. 3 edges for the default.
- pulse_out is registered: high for exactly one clock per terminal count, with no glitches.
- RPT with INIT = 1 on clock source: a terminal tick every cycle, so pulse_out stays continuously high and DONE stays set.
- Channels are fully independent; the only shared resource is the read mux.

## Test plan
- Reset with random pre-state → all outputs and all readbacks 0; COUNT0 reads 0x0000 after release.
- MODE0 = 0, INIT0 = 5 → COUNT0 reads 5,4,3,2,1 on successive cycles. pulse_out[0] is high in cycle 6 only. STATUS0 = 0x0001, and a second STATUS0 read returns 0x0000.
- MODE1 = 0x3 (external, reload), INIT1 = 3, eight cnt_in[1] pulses each 4 cycles wide → exactly two pulse_out[1] pulses, 3 edges apart. COUNT1 ends at 1 and RUN stays 1.
- INIT0 = 0 → RUN = 0, no pulse ever. Then INIT0 = 0xFFFF and a MODE0 write at count 0xFFF0 → counting freezes at 0xFFF0 and STATUS0 = 0x0000.
- STATUS0 read on the exact terminal-tick cycle → read returns 0x8000, and the next read returns 0x0001 (set beats clear).
- Reset asserted mid-count with INIT1 = 100, RPT = 1 → pulse_out and every register are 0 immediately, and no pulse follows after release.
